// File: rtl/rs_bank_arbiter.sv
// rs_bank_arbiter
//   Shares an external bank of N RS flip-flops between two requesters. Each
//   accepted command (hold / set / clear / special) runs through a fixed
//   four-cycle sequence: IDLE (grant) -> DRIVE (one-cycle S or R pulse) ->
//   CHECK (read back) -> RESP (response strobe). Only one bit is ever driven,
//   and set and reset are never driven together.
//
//   Build option: RS_BANK_FORBID_CHECK_EN
//     defined   : op 11 is the forbidden S=R=1 command. Nothing is driven and
//                 the response reports an error with the current bank bit.
//     undefined : op 11 toggles the target bit.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester command valid (bit 0 = requester 0)
//   req_idx0/1   target bit index of requester 0/1
//   req_op0/1    op of requester 0/1: 00 hold, 01 set, 10 clear, 11 special
//   req_ready    per-requester accept, combinational, at most one bit high
//   bank_s       set drive into the bank, one-hot or zero
//   bank_r       reset drive into the bank, one-hot or zero
//   bank_q       bank Q outputs
//   rsp_valid    one-cycle response strobe
//   rsp_id       requester that owns the response
//   rsp_q        bank bit read back in CHECK (0 for a bad index)
//   rsp_err      readback mismatch, bad index or rejected op
module rs_bank_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  input  logic [IDXW-1:0] req_idx0,
  input  logic [1:0]      req_op0,
  input  logic [IDXW-1:0] req_idx1,
  input  logic [1:0]      req_op1,
  output logic [1:0]      req_ready,
  output logic [N-1:0]    bank_s,
  output logic [N-1:0]    bank_r,
  input  logic [N-1:0]    bank_q,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic            rsp_q,
  output logic            rsp_err
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_SPEC = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_RESP} state_t;

  // Control state
  state_t          state_q;
  logic            last_grant_q;
  logic [N-1:0]    bank_s_q;
  logic [N-1:0]    bank_r_q;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic            rsp_q_q;
  logic            rsp_err_q;

  // Transaction context captured at grant
  logic [IDXW-1:0] idx_q;
  logic            id_q;
  logic            exp_q;
  logic            bad_q;
  logic            forbid_q;

  // Grant-cycle decode
  logic            gnt_any;
  logic            id_d;
  logic [IDXW-1:0] idx_d;
  logic [1:0]      op_d;
  logic            bad_d;
  logic            q0_d;
  logic            exp_d;
  logic            forbid_d;
  logic            drive_d;

  // Readback decode
  logic            qc;
  logic            chk_q;
  logic            chk_err;

  function automatic logic idx_in_range(input logic [IDXW-1:0] idx);
    return (int'(idx) < N);
  endfunction

  // Out-of-range indices read as 0 rather than X.
  function automatic logic read_bit(input logic [N-1:0] q, input logic [IDXW-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx) == i) b = q[i];
    end
    return b;
  endfunction

  // Out-of-range indices decode to all zeros.
  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    gnt_any = |req_valid;
    // Under contention the requester that did not win last time goes first.
    case (req_valid)
      2'b10:   id_d = 1'b1;
      2'b11:   id_d = ~last_grant_q;
      default: id_d = 1'b0;
    endcase

    idx_d = id_d ? req_idx1 : req_idx0;
    op_d  = id_d ? req_op1  : req_op0;
    bad_d = !idx_in_range(idx_d);
    q0_d  = read_bit(bank_q, idx_d);

    case (op_d)
      OP_SET:  exp_d = 1'b1;
      OP_CLR:  exp_d = 1'b0;
      OP_HOLD: exp_d = q0_d;
      default: exp_d = ~q0_d;
    endcase

`ifdef RS_BANK_FORBID_CHECK_EN
    forbid_d = (op_d == OP_SPEC);
`else
    forbid_d = 1'b0;
`endif

    drive_d = !bad_d && !forbid_d && (op_d != OP_HOLD);
  end

  // Ready is gated by reset_n so that it is also low while reset is held.
  assign req_ready = (reset_n && (state_q == ST_IDLE) && gnt_any)
                   ? (id_d ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    qc      = read_bit(bank_q, idx_q);
    chk_q   = bad_q ? 1'b0 : qc;
    chk_err = bad_q | forbid_q | (qc != exp_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      bank_s_q     <= '0;
      bank_r_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_q_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            state_q      <= ST_DRIVE;
            last_grant_q <= id_d;
            // Exactly one of S/R can be loaded, and only for a single bit.
            if (drive_d) begin
              bank_s_q <= exp_d ? onehot(idx_d) : '0;
              bank_r_q <= exp_d ? '0 : onehot(idx_d);
            end
          end
        end
        ST_DRIVE: begin
          bank_s_q <= '0;
          bank_r_q <= '0;
          state_q  <= ST_CHECK;
        end
        ST_CHECK: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_q_q     <= chk_q;
          rsp_err_q   <= chk_err;
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Context registers only load at grant and need no reset.
  always_ff @(posedge clock) begin
    if ((state_q == ST_IDLE) && gnt_any) begin
      idx_q    <= idx_d;
      id_q     <= id_d;
      exp_q    <= exp_d;
      bad_q    <= bad_d;
      forbid_q <= forbid_d;
    end
  end

  assign bank_s    = bank_s_q;
  assign bank_r    = bank_r_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rs_bank_arbiter.sv
// Testbench for rs_bank_arbiter: a clocked RS bank model with stuck-at masks,
// a transaction-level reference model checked every falling edge, directed
// scenarios with literal expectations, and a randomized two-requester phase.
// A second instance with N=6 covers the out-of-range index case.
module tb_rs_bank_arbiter;
  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [IDXW-1:0] req_idx0, req_idx1;
  logic [1:0]      req_op0, req_op1;
  logic [1:0]      req_ready;
  logic [N-1:0]    bank_s, bank_r, bank_q;
  logic            rsp_valid, rsp_id, rsp_q, rsp_err;

  logic [N-1:0]    bank_reg = '0;
  logic [N-1:0]    stuck0   = '0;
  logic [N-1:0]    stuck1   = '0;

  logic [1:0]      v6;
  logic [2:0]      idx6;
  logic [1:0]      op6;
  logic [1:0]      rdy6;
  logic [5:0]      s6, r6;
  logic [5:0]      q6reg = '0;
  logic            rv6, rid6, rq6, rerr6;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int              cyc   = 0;
  int              t_acc = -100;
  bit              busy;
  logic            m_last;
  logic [N-1:0]    p_s, p_r;
  logic            p_id, p_q, p_err;
  logic            h_id, h_q, h_err;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    bank_reg <= (bank_reg | bank_s) & ~bank_r;
    q6reg    <= (q6reg | s6) & ~r6;
  end
  assign bank_q = (bank_reg & ~stuck0) | stuck1;

  rs_bank_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid),
    .req_idx0(req_idx0), .req_op0(req_op0), .req_idx1(req_idx1), .req_op1(req_op1),
    .req_ready(req_ready), .bank_s(bank_s), .bank_r(bank_r), .bank_q(bank_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err)
  );

  rs_bank_arbiter #(.N(6), .IDXW(3)) dut6 (
    .clock(clock), .reset_n(reset_n), .req_valid(v6),
    .req_idx0(idx6), .req_op0(op6), .req_idx1(3'd0), .req_op1(2'b00),
    .req_ready(rdy6), .bank_s(s6), .bank_r(r6), .bank_q(q6reg),
    .rsp_valid(rv6), .rsp_id(rid6), .rsp_q(rq6), .rsp_err(rerr6)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of the reference model, evaluated at the falling edge.
  task automatic model_check();
    logic [1:0]   er;
    logic         g;
    logic [2:0]   idx;
    logic [1:0]   op;
    logic         q0, nv, qc, bad, forbid;
    logic [N-1:0] es, erv;
    er = 2'b00; g = 1'b0; idx = '0; op = '0;
    q0 = 1'b0; nv = 1'b0; qc = 1'b0; bad = 1'b0; forbid = 1'b0;
    es = '0; erv = '0;
    cyc++;
    chk("s_and_r", 32'(bank_s & bank_r), 32'd0);
    if (!reset_n) begin
      chk("reset_outputs", 32'({req_ready, bank_s, bank_r, rsp_valid, rsp_id, rsp_q, rsp_err}), 32'd0);
      busy = 1'b0; m_last = 1'b1;
      h_id = 1'b0; h_q = 1'b0; h_err = 1'b0;
    end else begin
      if (busy && (cyc - t_acc >= 4)) busy = 1'b0;
      if (!busy && (req_valid != 2'b00)) begin
        if (req_valid == 2'b11) g = ~m_last;
        else                    g = req_valid[1];
        er = g ? 2'b10 : 2'b01;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      if (er != 2'b00) begin
        idx = g ? req_idx1 : req_idx0;
        op  = g ? req_op1  : req_op0;
        bad = (int'(idx) >= N);
        q0  = bad ? 1'b0 : bank_q[idx];
`ifdef RS_BANK_FORBID_CHECK_EN
        forbid = (op == 2'b11);
`endif
        case (op)
          2'b00:   nv = q0;
          2'b01:   nv = 1'b1;
          2'b10:   nv = 1'b0;
          default: nv = ~q0;
        endcase
        p_s = '0; p_r = '0;
        if (bad || forbid || (op == 2'b00)) begin
          qc = q0;
        end else begin
          if (nv) p_s = N'(1) << idx;
          else    p_r = N'(1) << idx;
          qc = (nv & ~stuck0[idx]) | stuck1[idx];
        end
        p_id  = g;
        p_q   = bad ? 1'b0 : qc;
        p_err = bad | forbid | (qc != nv);
        m_last = g;
        busy   = 1'b1;
        t_acc  = cyc;
      end
      if (busy && (cyc == t_acc + 1)) begin es = p_s; erv = p_r; end
      chk("bank_s", 32'(bank_s), 32'(es));
      chk("bank_r", 32'(bank_r), 32'(erv));
      if (busy && (cyc == t_acc + 3)) begin
        h_id = p_id; h_q = p_q; h_err = p_err;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
      end
      chk("rsp_fields", 32'({rsp_id, rsp_q, rsp_err}), 32'({h_id, h_q, h_err}));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    model_check();
  endtask

  task automatic drain(input int n);
    repeat (n) begin tick(); cycle(); end
  endtask

  // Returns at rising edge + 1 of the DRIVE cycle with valid dropped.
  task automatic issue(input int r, input logic [2:0] idx, input logic [1:0] op);
    bit got = 1'b0;
    tick();
    if (r == 0) begin req_idx0 = idx; req_op0 = op; end
    else        begin req_idx1 = idx; req_op1 = op; end
    req_valid[r] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (req_ready[r]) begin got = 1'b1; break; end
      tick();
    end
    chk("issue_accept", 32'(got), 32'd1);
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic issue6(input logic [2:0] idx, input logic [1:0] op);
    bit got = 1'b0;
    tick();
    idx6 = idx; op6 = op; v6 = 2'b01;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (rdy6[0]) begin got = 1'b1; break; end
      tick();
    end
    chk("n6_accept", 32'(got), 32'd1);
    tick();
    v6 = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    bit [1:0] seen;
    logic     exp_id;
    int       nresp;
    reset_n = 1'b0;
    req_valid = 2'b11;
    req_idx0 = 3'd3; req_op0 = 2'b01;
    req_idx1 = 3'd6; req_op1 = 2'b10;
    v6 = 2'b00; idx6 = '0; op6 = '0;
    busy = 1'b0; m_last = 1'b1;
    h_id = 1'b0; h_q = 1'b0; h_err = 1'b0;
    p_s = '0; p_r = '0; p_id = 1'b0; p_q = 1'b0; p_err = 1'b0;

    // Reset held with both requesters valid, then first grant and set idx 3
    repeat (3) cycle();
    chk("reset_ready", 32'(req_ready), 32'd0);
    tick(); reset_n = 1'b1;
    cycle(); chk("first_grant", 32'(req_ready), 32'h1);
    tick(); req_valid[0] = 1'b0;
    cycle(); chk("set3_drive_s", 32'(bank_s), 32'h08); chk("set3_drive_r", 32'(bank_r), 32'h00);
    tick(); cycle(); chk("set3_drive_off", 32'(bank_s), 32'h00);
    tick(); cycle(); chk("set3_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1010);
    tick(); cycle(); chk("second_grant", 32'(req_ready), 32'h2);
    tick(); req_valid[1] = 1'b0;
    cycle();
    drain(5);

    // Stuck-at-0 on bit 5: set fails readback, hold does not drive
    tick(); stuck0 = 8'h20;
    cycle();
    issue(0, 3'd5, 2'b01);
    cycle(); chk("stuck_set_drive", 32'(bank_s), 32'h20);
    tick(); cycle(); tick(); cycle();
    chk("stuck_set_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1001);
    issue(0, 3'd5, 2'b00);
    cycle(); chk("hold_nodrive", 32'({bank_s, bank_r}), 32'd0);
    tick(); cycle(); tick(); cycle();
    chk("hold_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1000);
    tick(); stuck0 = 8'h00;
    cycle();

    // Special op on idx 2 with Q[2]=1
    issue(1, 3'd2, 2'b01);
    cycle(); tick(); cycle(); tick(); cycle();
    chk("set2_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1110);
    issue(1, 3'd2, 2'b11);
    cycle();
`ifdef RS_BANK_FORBID_CHECK_EN
    chk("spec_nodrive", 32'({bank_s, bank_r}), 32'd0);
`else
    chk("spec_toggle_s", 32'(bank_s), 32'h00);
    chk("spec_toggle_r", 32'(bank_r), 32'h04);
`endif
    tick(); cycle(); tick(); cycle();
`ifdef RS_BANK_FORBID_CHECK_EN
    chk("spec_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1111);
`else
    chk("spec_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1100);
`endif

    // Reset asserted during DRIVE
    issue(0, 3'd4, 2'b01);
    chk("pre_reset_drive", 32'(bank_s), 32'h10);
    #1 reset_n = 1'b0;
    #1 chk("async_drop", 32'({bank_s, bank_r}), 32'd0);
    cycle();
    tick(); cycle();
    tick(); reset_n = 1'b1;
    cycle(); chk("no_rsp_after_reset_a", 32'(rsp_valid), 32'd0);
    tick(); cycle(); chk("no_rsp_after_reset_b", 32'(rsp_valid), 32'd0);
    issue(0, 3'd4, 2'b01);
    cycle(); tick(); cycle(); tick(); cycle();
    chk("post_reset_rsp", 32'({rsp_valid, rsp_id, rsp_q, rsp_err}), 32'b1010);
    drain(2);

    // Contention on idx 1: requester 0 clears, requester 1 sets
    tick();
    req_idx0 = 3'd1; req_op0 = 2'b10;
    req_idx1 = 3'd1; req_op1 = 2'b01;
    req_valid = 2'b11;
    exp_id = 1'b1;
    nresp = 0;
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (rsp_valid) begin
        chk("alt_id", 32'(rsp_id), 32'(exp_id));
        chk("alt_q", 32'(rsp_q), 32'(exp_id));
        exp_id = ~exp_id;
        nresp++;
      end
      tick();
    end
    req_valid = 2'b00;
    chk("alt_count", 32'(nresp), 32'd8);
    cycle();
    drain(5);

    // N=6 instance: out-of-range index, then a valid one
    issue6(3'd7, 2'b01);
    cycle(); chk("n6_bad_nodrive", 32'({s6, r6}), 32'd0);
    tick(); cycle(); tick(); cycle();
    chk("n6_bad_rsp", 32'({rv6, rid6, rq6, rerr6}), 32'b1001);
    issue6(3'd5, 2'b01);
    cycle(); chk("n6_set5_drive", 32'(s6), 32'h20);
    tick(); cycle(); tick(); cycle();
    chk("n6_set5_rsp", 32'({rv6, rid6, rq6, rerr6}), 32'b1010);
    drain(2);

    // Randomized two-requester traffic with stuck bits
    tick(); stuck0 = 8'h20; stuck1 = 8'h80;
    cycle();
    seen = 2'b00;
    for (int k = 0; k < 800; k++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && seen[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && ($urandom_range(0, 2) != 0)) begin
          if (r == 0) begin
            req_idx0 = 3'($urandom_range(0, 7));
            req_op0  = 2'($urandom_range(0, 3));
          end else begin
            req_idx1 = 3'($urandom_range(0, 7));
            req_op1  = 2'($urandom_range(0, 3));
          end
          req_valid[r] = 1'b1;
        end
      end
      cycle();
      seen = req_ready;
    end
    tick(); req_valid = 2'b00;
    cycle();
    drain(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_bank_arbiter.md
Name: rs_bank_arbiter

Overview:
- Controller that shares an external bank of N RS flip-flops between two requesters.
- Each requester issues set, clear, hold or toggle commands for one bit. The block arbitrates round-robin and drives one-cycle S/R pulses into the bank.
- It reads the bit back and returns a response carrying status.
- It guarantees the bank never sees S=R=1 on any bit.

Parameters:
- N, 8, number of RS flip-flops in the controlled bank.
- IDXW, 3, width of the bit-index field; must satisfy 2**IDXW >= N.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester command valid (bit 0 = requester 0).
- req_idx0  input  IDXW  requester 0 target bit index.
- req_op0  input  2  requester 0 op: 00 hold, 01 set, 10 clear, 11 special (see Optional Feature).
- req_idx1  input  IDXW  requester 1 target bit index.
- req_op1  input  2  requester 1 op, same encoding.
- req_ready  output  2  per-requester accept; at most one bit high.
- bank_s  output  N  set drive to the bank, one-hot or zero.
- bank_r  output  N  reset drive to the bank, one-hot or zero.
- bank_q  input  N  bank Q outputs.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  1  requester that owns the response.
- rsp_q  output  1  bank_q[idx] sampled in CHECK.
- rsp_err  output  1  readback mismatch, bad index or rejected op.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - bank_s, bank_r, req_ready, rsp_valid, rsp_id, rsp_q and rsp_err all go to 0.
  - last_grant goes to 1, so requester 0 wins the first contention.
- Reset mid-operation: the transaction is abandoned, no response is issued and the drive is removed immediately.
- FSM states: IDLE -> DRIVE -> CHECK -> RESP -> IDLE. DRIVE, CHECK and RESP each last exactly one cycle.
- IDLE:
  - If any req_valid bit is set, grant one requester. With a single requester, grant it. With both, grant the one that is not last_grant.
  - req_ready[g] is asserted combinationally in this cycle only.
  - Latch idx, op and id. Sample q0 = bank_q[idx]. Update last_grant to g.
- Expected value:
  - set: exp=1.
  - clear: exp=0.
  - hold: exp=q0.
  - toggle: exp=~q0.
- DRIVE:
  - If exp=1 and the op is not hold, bank_s[idx]=1.
  - If exp=0 and the op is not hold, bank_r[idx]=1.
  - Hold drives nothing.
  - bank_s & bank_r is 0 in every cycle, without exception.
- CHECK:
  - Outputs are zero.
  - Sample qc = bank_q[idx]. Set err if qc != exp.
- RESP:
  - rsp_valid=1 for one cycle, with rsp_id=id, rsp_q=qc, rsp_err=err.
  - rsp_q, rsp_id and rsp_err hold their values until the next RESP.
- Latency: accepted in cycle T, drive in T+1, rsp_valid in T+3. One transaction is in flight at a time, so maximum throughput is 1 per 4 cycles.
- Requests arriving outside IDLE are not accepted; requesters hold valid until ready.
- Bad index (idx >= N): no drive in DRIVE; rsp_err=1 and rsp_q=0.
- Both requesters valid with the same idx: serialized by the arbiter; the second sees the first's result in q0.

Optional Feature:
- Macro RS_BANK_FORBID_CHECK_EN.
- Defined: op 11 is treated as the forbidden S=R=1 command. No drive; response with rsp_err=1 and rsp_q = current bank_q[idx].
- Undefined: op 11 is toggle (exp=~q0), driven and checked as normal.

Test Plan:
- Reset with req_valid=2'b11 held -> all outputs 0. After release, requester 0 is granted first: req_ready=01 in the first IDLE cycle.
- Req0 set idx 3, bank model with Q=0 -> bank_s=0x08 for exactly one cycle at T+1, bank_r=0. rsp_valid at T+3 with rsp_id=0, rsp_q=1, rsp_err=0.
- Both requesters continuously valid (req0 clear idx 1, req1 set idx 1) -> grants alternate 0,1,0,1 every 4 cycles. Each response's rsp_q matches its op. bank_s & bank_r is never nonzero.
- Bank model stuck Q[5]=0; set idx 5 -> rsp_err=1, rsp_q=0. Hold on idx 5 -> rsp_err=0 and no drive.
- op 11 on idx 2 with Q[2]=1:
  - Macro defined -> no drive, rsp_err=1, rsp_q=1.
  - Macro undefined -> bank_r=0x04, rsp_q=0, rsp_err=0.
- Assert reset_n=0 during DRIVE -> bank_s/bank_r drop to 0 asynchronously, no rsp_valid is issued, and a new request after release completes normally. With N=6, idx 7 -> no drive, rsp_err=1.
